lsu_dmem_master: RTL

//  Load/store initiator driving the word-addressed, single-port data memory (comb read, sync write).

---
 rtl/lsu_dmem_master.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/lsu_dmem_master.sv
// Load/store initiator for a word-addressed single-port data memory (comb read, sync write).
// Define LSU_MISALIGN_SPLIT_EN to split word-spanning accesses; otherwise misaligned accesses error.
module lsu_dmem_master #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              mem_rw,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic [2:0] {IDLE, RD0, RD1, WR0, WR1, RESP} state_t;

  state_t state, state_nxt;

  logic              we_q;
  logic [1:0]        size_q;
  logic              uns_q;
  logic [ADDR_W-1:0] wi_q;
  logic [1:0]        off_q;
  logic [31:0]       wdata_q;
  logic              err_q;
  logic              span_q;
  logic [31:0]       buf0;
  logic [31:0]       buf1;
  logic [63:0]       merged;

  logic [ADDR_W-1:0] wi_in;
  logic [1:0]        off_in;
  logic              span_in;
  logic              hi_in;
  logic              err_in;
  logic              accept;

  function automatic logic [2:0] size_bytes(input logic [1:0] size);
    case (size)
      2'b00:   return 3'd1;
      2'b01:   return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  // Little-endian extract starting at byte offset, then sign/zero extend.
  function automatic logic [31:0] load_extend(input logic [63:0] dw, input logic [1:0] off,
                                              input logic [1:0] size, input logic uns);
    logic [31:0]        sh;
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic signed [31:0] r;
    sh = 32'(dw >> {off, 3'b000});
    b  = sh[7:0];
    h  = sh[15:0];
    case (size)
      2'b00:   r = uns ? {24'd0, sh[7:0]} : 32'(b);
      2'b01:   r = uns ? {16'd0, sh[15:0]} : 32'(h);
      default: r = sh;
    endcase
    return r;
  endfunction

  function automatic logic [63:0] merge_store(input logic [63:0] dw, input logic [31:0] wd,
                                              input logic [1:0] off, input logic [1:0] size);
    logic [3:0]  m4;
    logic [7:0]  lanes;
    logic [63:0] ins;
    logic [63:0] r;
    case (size)
      2'b00:   m4 = 4'b0001;
      2'b01:   m4 = 4'b0011;
      default: m4 = 4'b1111;
    endcase
    lanes = {4'd0, m4} << off;
    ins   = {32'd0, wd} << {off, 3'b000};
    r     = dw;
    for (int i = 0; i < 8; i++) begin
      if (lanes[i]) r[8*i +: 8] = ins[8*i +: 8];
    end
    return r;
  endfunction

  assign accept  = req_valid && (state == IDLE);
  assign wi_in   = req_addr[ADDR_W+1:2];
  assign off_in  = req_addr[1:0];
  assign span_in = ({1'b0, off_in} + size_bytes(req_size)) > 3'd4;
  assign hi_in   = (req_addr >> (ADDR_W + 2)) != 32'd0;

`ifdef LSU_MISALIGN_SPLIT_EN
  // The last word has no successor: a spanning access there errors instead of wrapping.
  assign err_in = (req_size == 2'b11) | hi_in | (span_in & (&wi_in));
`else
  logic misal;
  assign misal  = ((req_size == 2'b01) & off_in[0]) | ((req_size == 2'b10) & (off_in != 2'b00));
  assign err_in = (req_size == 2'b11) | hi_in | misal;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      we_q    <= req_we;
      size_q  <= req_size;
      uns_q   <= req_unsigned;
      wi_q    <= wi_in;
      off_q   <= off_in;
      wdata_q <= req_wdata;
      err_q   <= err_in;
      span_q  <= span_in;
    end
    if (state == RD0) buf0 <= mem_rdata;
    if (state == RD1) buf1 <= mem_rdata;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (req_valid) begin
          if (err_in)                                      state_nxt = RESP;
          else if (!req_we)                                state_nxt = RD0;
          else if (req_size == 2'b10 && off_in == 2'b00)   state_nxt = WR0;
          else                                             state_nxt = RD0;
        end
      end
      RD0:     state_nxt = span_q ? RD1 : (we_q ? WR0 : RESP);
      RD1:     state_nxt = we_q ? WR0 : RESP;
      WR0:     state_nxt = span_q ? WR1 : RESP;
      WR1:     state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Aligned SW never reads, so stale buffer lanes are fully overwritten by the merge.
  assign merged = merge_store({buf1, buf0}, wdata_q, off_q, size_q);

  always_comb begin
    req_ready = (state == IDLE);
    rsp_valid = 1'b0;
    rsp_rdata = 32'd0;
    rsp_err   = 1'b0;
    mem_rw    = 1'b0;
    mem_addr  = '0;
    mem_wdata = 32'd0;
    unique case (state)
      RD0: mem_addr = wi_q;
      RD1: mem_addr = wi_q + ADDR_W'(1);
      WR0: begin
        mem_rw    = 1'b1;
        mem_addr  = wi_q;
        mem_wdata = merged[31:0];
      end
      WR1: begin
        mem_rw    = 1'b1;
        mem_addr  = wi_q + ADDR_W'(1);
        mem_wdata = merged[63:32];
      end
      RESP: begin
        rsp_valid = 1'b1;
        rsp_err   = err_q;
        if (!err_q && !we_q) rsp_rdata = load_extend({buf1, buf0}, off_q, size_q, uns_q);
      end
      default: ;
    endcase
  end

endmodule
